// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit: gate op encoding and the bitwise gate function.
package logic_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_NOT  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_NOR  = 3'd4;
    localparam op_t OP_XOR  = 3'd5;
    localparam op_t OP_XNOR = 3'd6;
    localparam op_t OP_PASS = 3'd7;

    localparam int unsigned MAX_WIDTH = 64;

    // Evaluated at full width, then masked so inverting ops leave no stray high bits.
    function automatic logic [MAX_WIDTH-1:0] gate_fn(
        input op_t                  op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] y;
        logic [MAX_WIDTH-1:0] mask;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = b;
        endcase
        mask = (width >= MAX_WIDTH) ? {MAX_WIDTH{1'b1}} : ((64'd1 << width) - 64'd1);
        return y & mask;
    endfunction

endpackage

// File: rtl/logic_gate_bank.sv
// Purely combinational WIDTH-bit gate selector; shared with later ALU work.
module logic_gate_bank
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = WIDTH'(gate_fn(op_i, MAX_WIDTH'(a_i), MAX_WIDTH'(b_i), WIDTH));

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered gate unit: one-deep output stage with valid/ready, result flags and an
// accumulator that can replace operand A.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             parity_q, parity_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             accept;
    op_t              gate_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] gate_y;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign gate_op  = op;
    assign op_a     = acc_en ? acc_q : a;

    logic_gate_bank #(
        .WIDTH (WIDTH)
    ) u_gate_bank (
        .op_i (gate_op),
        .a_i  (op_a),
        .b_i  (b),
        .y_o  (gate_y)
    );

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        ones_d   = ones_q;
        parity_d = parity_q;
        acc_d    = acc_q;
        if (accept) begin
            valid_d  = 1'b1;
            result_d = gate_y;
            zero_d   = ~|gate_y;
            ones_d   = &gate_y;
            parity_d = ^gate_y;
            acc_d    = gate_y;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // Clear takes priority; the same-cycle accept already used the old value as A.
        if (acc_clr) begin
            acc_d = ACC_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ones_q   <= 1'b0;
            parity_q <= 1'b0;
            acc_q    <= ACC_INIT;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ones_q   <= ones_d;
            parity_q <= parity_d;
            acc_q    <= acc_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe with a result scoreboard popped on each handshake.
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, acc_en, acc_clr, out_valid, out_ready;
    logic [7:0] a, b, result;
    logic [2:0] op;
    logic       zero, ones, parity;

    logic       w1_in_valid, w1_in_ready, w1_acc_en, w1_acc_clr, w1_out_valid, w1_out_ready;
    logic [0:0] w1_a, w1_b, w1_result;
    logic [2:0] w1_op;
    logic       w1_zero, w1_ones, w1_parity;

    logic        w16_in_valid, w16_in_ready, w16_acc_en, w16_acc_clr, w16_out_valid, w16_out_ready;
    logic [15:0] w16_a, w16_b, w16_result;
    logic [2:0]  w16_op;
    logic        w16_zero, w16_ones, w16_parity;

    int         checks;
    int         errors;
    logic       mdl_valid;
    logic [7:0] sb_q [$];
    logic [7:0] sweep_exp [8];

    logic_unit_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .op(op), .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .ones(ones), .parity(parity)
    );

    logic_unit_pipe #(.WIDTH(1), .ACC_INIT(1'b0)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready), .a(w1_a),
        .b(w1_b), .op(w1_op), .acc_en(w1_acc_en), .acc_clr(w1_acc_clr),
        .out_valid(w1_out_valid), .out_ready(w1_out_ready), .result(w1_result),
        .zero(w1_zero), .ones(w1_ones), .parity(w1_parity)
    );

    logic_unit_pipe #(.WIDTH(16), .ACC_INIT(16'h0000)) u_dut_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
        .a(w16_a), .b(w16_b), .op(w16_op), .acc_en(w16_acc_en), .acc_clr(w16_acc_clr),
        .out_valid(w16_out_valid), .out_ready(w16_out_ready), .result(w16_result),
        .zero(w16_zero), .ones(w16_ones), .parity(w16_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the 8-bit DUT: consume on handshake, push on accept, check out_valid.
    task automatic tick(input logic [7:0] exp_res);
        logic       take;
        logic [7:0] e;
        #1;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("result", result, e);
                chk("zero", zero, e == 8'h00);
                chk("ones", ones, e == 8'hFF);
                chk("parity", parity, ^e);
            end
        end
        take = in_valid && (!mdl_valid || out_ready);
        chk("in_ready", in_ready, !mdl_valid || out_ready);
        if (take) sb_q.push_back(exp_res);
        @(posedge clk);
        #1;
        if (take) mdl_valid = 1'b1;
        else if (out_ready) mdl_valid = 1'b0;
        chk("out_valid", out_valid, mdl_valid);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mdl_valid = 1'b0;
        sweep_exp = '{8'h81, 8'hE7, 8'h3C, 8'h7E, 8'h18, 8'h66, 8'h99, 8'hA5};
        rst_n = 1'b0;
        {in_valid, acc_en, acc_clr, out_ready, a, b, op} = '0;
        {w1_in_valid, w1_acc_en, w1_acc_clr, w1_out_ready, w1_a, w1_b, w1_op} = '0;
        {w16_in_valid, w16_acc_en, w16_acc_clr, w16_out_ready, w16_a, w16_b, w16_op} = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 8'h00);
        chk("rst_zero", zero, 1);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_ones", ones, 0);
        chk("rel_parity", parity, 0);
        chk("rel_result", result, 8'h00);

        // Sweep all ops back-to-back.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'hC3;
        b = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick(sweep_exp[i]);
        end
        in_valid = 1'b0;
        tick(8'h00);

        // Backpressure: second op must wait while the first is held.
        in_valid = 1'b1;
        op = 3'd5;
        a = 8'hFF;
        b = 8'h0F;
        tick(8'hF0);
        out_ready = 1'b0;
        op = 3'd0;
        a = 8'h3C;
        b = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick(8'h3C);
            chk("hold_result", result, 8'hF0);
        end
        out_ready = 1'b1;
        tick(8'h3C);
        chk("bp_second", result, 8'h3C);
        in_valid = 1'b0;
        tick(8'h00);

        // Accumulate mode.
        acc_clr = 1'b1;
        tick(8'h00);
        acc_clr  = 1'b0;
        in_valid = 1'b1;
        acc_en   = 1'b1;
        a  = 8'h55;
        op = 3'd1;
        b  = 8'h01;
        tick(8'h01);
        b = 8'h80;
        tick(8'h81);
        op = 3'd5;
        b  = 8'h81;
        tick(8'h00);
        op = 3'd1;
        b  = 8'h5A;
        tick(8'h5A);
        acc_clr = 1'b1;
        b = 8'h01;
        tick(8'h5B);
        acc_clr = 1'b0;
        b = 8'h00;
        tick(8'h00);
        in_valid = 1'b0;
        acc_en   = 1'b0;
        tick(8'h00);

        // Width 1 and width 16 flag checks.
        w1_in_valid = 1'b1;
        w1_out_ready = 1'b1;
        w1_op = 3'd3;
        w16_in_valid = 1'b1;
        w16_out_ready = 1'b1;
        w16_op = 3'd2;
        w16_b = 16'h1234;
        chk("w1_in_ready", w1_in_ready, 1);
        chk("w16_in_ready", w16_in_ready, 1);
        tick(8'h00);
        chk("w1_valid", w1_out_valid, 1);
        chk("w1_result", w1_result, 1);
        chk("w1_ones", w1_ones, 1);
        chk("w1_zero", w1_zero, 0);
        chk("w1_parity", w1_parity, 1);
        chk("w16_valid", w16_out_valid, 1);
        chk("w16_result", w16_result, 16'hFFFF);
        chk("w16_ones", w16_ones, 1);
        chk("w16_zero", w16_zero, 0);
        chk("w16_parity", w16_parity, 0);
        w1_in_valid = 1'b0;
        w16_in_valid = 1'b0;

        // Asynchronous reset while a result is held.
        in_valid = 1'b1;
        op = 3'd1;
        a = 8'h0F;
        b = 8'hF0;
        tick(8'hFF);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_result", result, 8'h00);
        chk("async_zero", zero, 1);
        sb_q.delete();
        mdl_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick(8'h00);

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
